// File: rtl/m_data_memory_pkg.sv
// Shared store-type encodings and data-memory address map, used by the decoder,
// the data memory and the load-extension stage.
package m_data_memory_pkg;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam logic [1:0] STORE_SW   = 2'b01;
  localparam logic [1:0] STORE_SH   = 2'b10;
  localparam logic [1:0] STORE_SB   = 2'b11;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT = 32'h0000_3000;

  // Byte-wise merge: enabled lanes take the new data, the rest keep the old word.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/m_data_memory_if.sv
// Memory-stage bus between the pipeline (master) and the data memory (slave).
interface m_data_memory_if;

  logic [31:0] M_PC;
  logic [31:0] M_StoreAddr;
  logic [31:0] M_StoreData;
  logic [1:0]  M_StoreOp;
  logic [31:0] M_MemoryData;
  logic        M_StoreErr;

  modport master (
    output M_PC,
    output M_StoreAddr,
    output M_StoreData,
    output M_StoreOp,
    input  M_MemoryData,
    input  M_StoreErr
  );

  modport slave (
    input  M_PC,
    input  M_StoreAddr,
    input  M_StoreData,
    input  M_StoreOp,
    output M_MemoryData,
    output M_StoreErr
  );

endinterface

// File: rtl/m_data_memory_store_align.sv
// Combinational store aligner: byte enables, lane-placed data and misalignment
// flag from the store type and the low two address bits.
import m_data_memory_pkg::*;

module m_store_align (
  input  logic [1:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  output logic [3:0]  be,
  output logic [31:0] laneData,
  output logic        misalign
);

  always_comb begin
    be       = 4'b0000;
    laneData = 32'h0000_0000;
    misalign = 1'b0;
    case (op)
      STORE_SW: begin
        be       = 4'b1111;
        laneData = storeData;
        misalign = (addrLo != 2'b00);
      end
      STORE_SH: begin
        be       = addrLo[1] ? 4'b1100 : 4'b0011;
        laneData = {2{storeData[15:0]}};
        misalign = addrLo[0];
      end
      STORE_SB: begin
        be       = 4'b0001 << addrLo;
        laneData = {4{storeData[7:0]}};
        misalign = 1'b0;
      end
      default: begin
        be       = 4'b0000;
        laneData = 32'h0000_0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/m_data_memory.sv
// Memory-stage data memory: byte-enabled synchronous stores, combinational raw-word read.
// Optional write log compiled in with `define DM_WRITE_LOG_EN.
import m_data_memory_pkg::*;

module m_data_memory #(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 12
) (
  input  logic          clk,
  input  logic          reset,
  m_data_memory_if.slave bus
);

  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] wordIdx;
  logic              inRange;
  logic [31:0]       rdWord;
  logic [3:0]        alignBe;
  logic [31:0]       laneData;
  logic              misalign;
  logic              storeErr;
  logic [3:0]        be;
  logic [31:0]       mergedWord;

  m_store_align u_align (
    .op        (bus.M_StoreOp),
    .addrLo    (bus.M_StoreAddr[1:0]),
    .storeData (bus.M_StoreData),
    .be        (alignBe),
    .laneData  (laneData),
    .misalign  (misalign)
  );

  assign wordIdx = bus.M_StoreAddr[ADDR_W+1:2];
  assign inRange = (bus.M_StoreAddr < BYTE_LIMIT);

  // Read path: raw word, zero outside the array so stale index aliases never leak.
  assign rdWord           = inRange ? mem[wordIdx] : 32'h0000_0000;
  assign bus.M_MemoryData = rdWord;

  assign storeErr       = (bus.M_StoreOp != STORE_NONE) && (misalign || !inRange);
  assign bus.M_StoreErr = storeErr;
  assign be             = storeErr ? 4'b0000 : alignBe;

  // Merge against the pre-edge contents, so back-to-back partial stores compose.
  assign mergedWord = mergeBytes(rdWord, laneData, be);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (be != 4'b0000) begin
      mem[wordIdx] <= mergedWord;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, bus.M_PC,
               {bus.M_StoreAddr[31:2], 2'b00}, mergedWord);
`endif
    end
  end

endmodule

// File: tb/tb_m_data_memory.sv
// Self-checking bench for m_data_memory: scenario tasks with a scoreboard queue of
// expected read word / store-error values popped when the DUT outputs are sampled.
module tb_m_data_memory;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd;
    logic        err;
  } step_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t expQ[$];

  m_data_memory_if bus ();

  m_data_memory #(.DEPTH_WORDS(3072), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int n);
    bus.M_StoreOp   = op;
    bus.M_StoreAddr = addr;
    bus.M_StoreData = data;
    bus.M_PC        = 32'h0040_0000 + 32'(n * 4);
  endtask

  task automatic test_reset();
    logic [31:0] addrs[4];
    exp_t e;
    addrs = '{32'h0000, 32'h0010, 32'h1000, 32'h2FFC};
    reset = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, addrs[i], 32'h0, i);
      expQ.push_back('{rd: 32'h0, err: 1'b0});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL reset_read addr=%h got %h want %h", addrs[i], bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL reset_err addr=%h got %b want %b", addrs[i], bus.M_StoreErr, e.err);
      end
      @(negedge clk);
    end
  endtask

  // Run a table of steps: one bus cycle each, checked mid-cycle, committed on the next edge.
  task automatic test_store_word();
    step_t s[2];
    exp_t  e;
    s = '{'{2'b01, 32'h0000, 32'h1234_5678, 32'h0000_0000, 1'b0},
          '{2'b00, 32'h0000, 32'h0,         32'h1234_5678, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(s[i].op, s[i].addr, s[i].data, i);
      expQ.push_back('{rd: s[i].rd, err: s[i].err});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL sw_read step %0d got %h want %h", i, bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL sw_err step %0d got %b want %b", i, bus.M_StoreErr, e.err);
      end
    end
  endtask

  task automatic test_partial();
    step_t s[4];
    exp_t  e;
    s = '{'{2'b10, 32'h0002, 32'hFFFF_ABCD, 32'h1234_5678, 1'b0},
          '{2'b11, 32'h0001, 32'h0000_00EE, 32'hABCD_5678, 1'b0},
          '{2'b11, 32'h0003, 32'h0000_0011, 32'hABCD_EE78, 1'b0},
          '{2'b00, 32'h0000, 32'h0,         32'h11CD_EE78, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(s[i].op, s[i].addr, s[i].data, i);
      expQ.push_back('{rd: s[i].rd, err: s[i].err});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL partial_read step %0d got %h want %h", i, bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL partial_err step %0d got %b want %b", i, bus.M_StoreErr, e.err);
      end
    end
  endtask

  task automatic test_misaligned();
    step_t s[5];
    exp_t  e;
    s = '{'{2'b01, 32'h0006, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1},
          '{2'b10, 32'h0003, 32'hFFFF_FFFF, 32'h11CD_EE78, 1'b1},
          '{2'b10, 32'h0001, 32'h0000_5555, 32'h11CD_EE78, 1'b1},
          '{2'b00, 32'h0004, 32'h0,         32'h0000_0000, 1'b0},
          '{2'b00, 32'h0000, 32'h0,         32'h11CD_EE78, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(s[i].op, s[i].addr, s[i].data, i);
      expQ.push_back('{rd: s[i].rd, err: s[i].err});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL misalign_read step %0d got %h want %h", i, bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL misalign_err step %0d got %b want %b", i, bus.M_StoreErr, e.err);
      end
    end
  endtask

  task automatic test_out_of_range();
    step_t s[6];
    exp_t  e;
    s = '{'{2'b01, 32'h3000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
          '{2'b01, 32'h2FFC, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
          '{2'b00, 32'h2FFC, 32'h0,         32'hDEAD_BEEF, 1'b0},
          '{2'b00, 32'h3000, 32'h0,         32'h0000_0000, 1'b0},
          '{2'b11, 32'h3001, 32'h0000_0077, 32'h0000_0000, 1'b1},
          '{2'b00, 32'h2FFC, 32'h0,         32'hDEAD_BEEF, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(s[i].op, s[i].addr, s[i].data, i);
      expQ.push_back('{rd: s[i].rd, err: s[i].err});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL range_read step %0d got %h want %h", i, bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL range_err step %0d got %b want %b", i, bus.M_StoreErr, e.err);
      end
    end
  endtask

  task automatic test_read_during_write();
    step_t s[2];
    exp_t  e;
    s = '{'{2'b01, 32'h0010, 32'h0000_00AA, 32'h0000_0000, 1'b0},
          '{2'b00, 32'h0010, 32'h0,         32'h0000_00AA, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(s[i].op, s[i].addr, s[i].data, i);
      expQ.push_back('{rd: s[i].rd, err: s[i].err});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL rdw_read step %0d got %h want %h", i, bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL rdw_err step %0d got %b want %b", i, bus.M_StoreErr, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[8];
    exp_t  e;
    s = '{'{2'b11, 32'h0020, 32'h0000_0001, 32'h0000_0000, 1'b0},
          '{2'b11, 32'h0021, 32'h0000_0002, 32'h0000_0001, 1'b0},
          '{2'b11, 32'h0022, 32'h0000_0003, 32'h0000_0201, 1'b0},
          '{2'b11, 32'h0023, 32'h0000_0004, 32'h0003_0201, 1'b0},
          '{2'b00, 32'h0020, 32'h0,         32'h0403_0201, 1'b0},
          '{2'b01, 32'h0024, 32'hCAFE_F00D, 32'h0000_0000, 1'b0},
          '{2'b10, 32'h0026, 32'h9999_1234, 32'hCAFE_F00D, 1'b0},
          '{2'b00, 32'h0024, 32'h0,         32'h1234_F00D, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(s[i].op, s[i].addr, s[i].data, i);
      expQ.push_back('{rd: s[i].rd, err: s[i].err});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL b2b_read step %0d got %h want %h", i, bus.M_MemoryData, e.rd);
      end
      checks++;
      if (bus.M_StoreErr !== e.err) begin
        errors++;
        $display("FAIL b2b_err step %0d got %b want %b", i, bus.M_StoreErr, e.err);
      end
    end
  endtask

  task automatic test_reset_with_store();
    logic [31:0] addrs[5];
    exp_t e;
    addrs = '{32'h0000, 32'h0010, 32'h0020, 32'h0024, 32'h2FFC};
    @(negedge clk);
    reset = 1'b1;
    drive(2'b01, 32'h0000, 32'h5555_5555, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, addrs[i], 32'h0, i);
      expQ.push_back('{rd: 32'h0, err: 1'b0});
      #1;
      e = expQ.pop_front();
      checks++;
      if (bus.M_MemoryData !== e.rd) begin
        errors++;
        $display("FAIL reset_store_read addr=%h got %h want %h", addrs[i], bus.M_MemoryData, e.rd);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 0);
    test_reset();
    test_store_word();
    test_partial();
    test_misaligned();
    test_out_of_range();
    test_read_during_write();
    test_back_to_back();
    test_reset_with_store();
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
